// File: rtl/fnd_decoder.sv
// Recovers the decimal value shown on a scanned 4-digit active-low 7-segment bus.
// Optional macro FND_DP_CAPTURE_EN captures and publishes the decimal points on dp.
module fnd_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [13:0] value,
    output logic        value_valid,
    output logic [3:0]  dp,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t      state, state_next;
    logic [3:0]  an_r, an_p;
    logic [7:0]  seg_r, seg_p;
    logic [7:0]  settle_cnt, settle_cnt_next;
    logic        changed, idle_an, sample_fire;

    logic        samp_valid;
    logic [3:0]  samp_an;
    logic [6:0]  samp_seg;

    logic        an_bad, seg_bad, samp_ok, samp_bad;
    logic [1:0]  slot;
    logic [3:0]  digit;

    logic [3:0][3:0] digits, digits_next;
    logic [3:0]  seen, seen_next;
    logic [3:0]  match_cnt, match_next;
    logic [13:0] last_value, frame_value;
    logic [3:0]  last_dp, frame_dp;
    logic        published, frame_done, same_as_last, publish;

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            an_r  <= 4'b1111;
            seg_r <= 8'hFF;
            an_p  <= 4'b1111;
            seg_p <= 8'hFF;
        end else begin
            an_r  <= an;
            seg_r <= seg;
            an_p  <= an_r;
            seg_p <= seg_r;
        end
    end

    assign changed = (an_r != an_p) || (seg_r != seg_p);
    assign idle_an = (an_r == 4'b1111);

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    // The change cycle clears the counter; SETTLE_CYCLES unchanged cycles then sample once.
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        sample_fire     = 1'b0;
        case (state)
            IDLE: begin
                if (!idle_an) begin
                    state_next      = SETTLE;
                    settle_cnt_next = 8'd0;
                end
            end
            SETTLE: begin
                if (idle_an) begin
                    state_next = IDLE;
                end else if (changed) begin
                    settle_cnt_next = 8'd0;
                end else if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                    sample_fire = 1'b1;
                    state_next  = HOLD;
                end else begin
                    settle_cnt_next = settle_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (idle_an) begin
                    state_next = IDLE;
                end else if (changed) begin
                    state_next      = SETTLE;
                    settle_cnt_next = 8'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            samp_valid <= 1'b0;
            samp_an    <= 4'b1111;
            samp_seg   <= 7'h7F;
        end else begin
            samp_valid <= sample_fire;
            samp_an    <= an_r;
            samp_seg   <= seg_r[6:0];
        end
    end

    always_comb begin
        an_bad = 1'b0;
        slot   = 2'd0;
        case (samp_an)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: an_bad = 1'b1;
        endcase
    end

    always_comb begin
        seg_bad = 1'b0;
        digit   = 4'd0;
        case (samp_seg)
            7'b1000000: digit = 4'd0;
            7'b1111001: digit = 4'd1;
            7'b0100100: digit = 4'd2;
            7'b0110000: digit = 4'd3;
            7'b0011001: digit = 4'd4;
            7'b0010010: digit = 4'd5;
            7'b0000010: digit = 4'd6;
            7'b1111000: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0010000: digit = 4'd9;
            7'b1111111: digit = 4'd0;
            default:    seg_bad = 1'b1;
        endcase
    end

    assign samp_ok  = samp_valid && !an_bad && !seg_bad;
    assign samp_bad = samp_valid && (an_bad || seg_bad);
    assign err      = samp_bad;

`ifdef FND_DP_CAPTURE_EN
    logic       samp_dp;
    logic [3:0] dp_slots, dp_slots_next, dp_q;

    always_comb begin
        dp_slots_next = dp_slots;
        if (samp_ok) dp_slots_next[slot] = samp_dp;
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            samp_dp  <= 1'b0;
            dp_slots <= 4'b0000;
            dp_q     <= 4'b0000;
        end else begin
            samp_dp  <= ~seg_r[7];
            dp_slots <= dp_slots_next;
            if (publish) dp_q <= frame_dp;
        end
    end

    assign frame_dp = dp_slots_next;
    assign dp       = dp_q;
`else
    assign frame_dp = 4'b0000;
    assign dp       = 4'b0000;
`endif

    // Frame value and stability decision are made in the cycle after the final sample.
    always_comb begin
        digits_next = digits;
        seen_next   = seen;
        if (samp_ok) begin
            digits_next[slot] = digit;
            seen_next         = seen | (4'b0001 << slot);
        end
        frame_done   = samp_ok && (seen_next == 4'b1111);
        frame_value  = 14'(digits_next[3]) * 14'd1000 + 14'(digits_next[2]) * 14'd100
                     + 14'(digits_next[1]) * 14'd10 + 14'(digits_next[0]);
        same_as_last = (match_cnt != 4'd0) && (frame_value == last_value) && (frame_dp == last_dp);
        if (!same_as_last)
            match_next = 4'd1;
        else if (match_cnt == 4'(STABLE_FRAMES))
            match_next = match_cnt;
        else
            match_next = match_cnt + 4'd1;
        publish = frame_done && (match_next == 4'(STABLE_FRAMES))
                  && (!published || frame_value != value || frame_dp != dp);
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            seen        <= 4'b0000;
            match_cnt   <= 4'd0;
            last_value  <= 14'd0;
            last_dp     <= 4'b0000;
            published   <= 1'b0;
            value       <= 14'd0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= publish;
            if (samp_bad) begin
                seen      <= 4'b0000;
                match_cnt <= 4'd0;
            end else if (samp_ok) begin
                digits <= digits_next;
                if (frame_done) begin
                    seen       <= 4'b0000;
                    last_value <= frame_value;
                    last_dp    <= frame_dp;
                    match_cnt  <= match_next;
                end else begin
                    seen <= seen_next;
                end
            end
            if (publish) begin
                value     <= frame_value;
                published <= 1'b1;
            end
        end
    end

endmodule
